poly_noise_bank: RTL
====================

// Module: poly_noise_bank
// PURPOSE
//  Multi-polynomial noise source for the POKEY audio/random path.
//  - Generates the poly4, poly5 and poly17/9 sequences together; all three advance on a shared clock-enable tick.
//  - Adds run-time 9/17 mode switching, seed loading and a handshaked RANDOM read capture.
//  - Feeds the audio channel distortion muxes and the RANDOM register read port.
// PARAMETERS
//  RAND_W    8   width of the RANDOM snapshot, 1..9; taken from long-register bits [RAND_W-1:0]
//  LONG_W    17  long-mode register width (taps fixed at bits LONG_W-1 and LONG_W-4)
//  SHORT_W   9   short-mode field width (taps fixed at bits SHORT_W-1 and SHORT_W-5)
// PORTS
//  clk        in   1        system clock
//  init_L     in   1        synchronous active-low reset
//  tick       in   1        advance enable (1.79 MHz strobe); all polys shift only when tick=1
//  sel9       in   1        1 = short (9-bit) mode, 0 = long (17-bit) mode
//  load       in   1        load seed into long register this cycle
//  seed       in   LONG_W   seed value for load
//  rd_stb     in   1        RANDOM read request (1-cycle pulse)
//  poly4_out  out  1        p4[3]
//  poly5_out  out  1        p5[4]
//  poly_out   out  1        mode_q ? p[SHORT_W-1] : p[LONG_W-1]
//  rand_q     out  RAND_W   captured RANDOM value
//  rand_vld   out  1        1-cycle pulse: rand_q updated
// BEHAVIOUR
//  - Reset (init_L=0 at clk edge): p4=4'hF, p5=5'h1F, p=all ones, mode_q=0, rand_q=0, rand_vld=0.
//    All other inputs are ignored. Reset mid-sequence restarts every sequence from all ones.
//  - poly4 (x^4+x^3+1) on tick: p4 <= {p4[2:0], p4[3]^p4[2]}; period 15.
//  - poly5 (x^5+x^3+1) on tick: p5 <= {p5[3:0], p5[4]^p5[2]}; period 31.
//  - Long mode (mode_q=0) on tick: p <= {p[15:0], p[16]^p[13]}; period 131071.
//  - Short mode (mode_q=1) on tick: p[8:0] <= {p[7:0], p[8]^p[4]}; p[16:9] held; period 511.
//  - Mode register:
//    - mode_q <= sel9 on every tick.
//    - A shift in the same cycle uses the old mode_q.
//    - The new mode therefore applies from the next tick; switching never clears the register.
//  - Load:
//    - load=1 sets p <= seed regardless of tick. load beats tick: p does not shift that cycle.
//    - p4, p5 and mode_q still advance on that tick.
//  - RANDOM capture:
//    - rd_stb=1 at edge N: rand_q <= p[RAND_W-1:0] using the pre-update value of p at edge N.
//    - rand_vld=1 for the cycle after edge N.
//    - Back-to-back rd_stb gives back-to-back captures and rand_vld held high.
//    - rd_stb and load in the same cycle: capture the old p.
//  - Outputs are registered-state taps only. No combinational path from any input to any output.
// CONFIGURATION
//  POLY_LOCKUP_GUARD_EN
//  - Defined: on a tick, if the active field is all zero, the whole of p (all LONG_W bits) is reloaded with all ones instead of shifting.
//    - Active field is p[16:0] in long mode, p[8:0] in short mode.
//    - Recovery takes exactly 1 tick.
//  - Undefined: no check; a zero active field stays zero (poly_out=0 forever) until the next load or reset.
// STRUCTURE
//  - Package poly_pkg:
//    - width constants P4_W=4, P5_W=5.
//    - tap constants (P4_TAPS, P5_TAPS, LONG_TAP_A/B, SHORT_TAP_A/B).
//    - typedef enum logic {MODE_LONG, MODE_SHORT} poly_mode_e.
//    - typedef for the long register.
//  - Sub-module lfsr_fixed #(W, TAP_A, TAP_B): clk, init_L, tick -> state.
//    - Reset is all ones; Fibonacci shift-left.
//    - Instantiated for poly4 and poly5.
//  - Long/short register, load, lockup guard and capture logic stay in poly_noise_bank.
// TESTING
//  - Reset release, long mode, tick every cycle:
//    - p goes 1FFFF -> 1FFFE -> 1FFFC.
//    - poly4_out sequence 1,1,1,1,0,...; repeats with period 15.
//    - poly5 repeats with period 31.
//    - poly17 returns to 1FFFF after 131071 ticks.
//  - sel9=1 held one tick after reset, then ticks:
//    - p[16:9] stays 8'hFF.
//    - low 9 bits go 1FF -> 1FE (first short-mode tick) -> 1FC; period 511.
//    - poly_out = p[8].
//  - rd_stb at p=1FFFE with RAND_W=8, same cycle as tick -> rand_q=8'hFE, rand_vld=1 one cycle later.
//    Back-to-back rd_stb -> two captures, rand_vld high 2 cycles.
//  - load=1 with seed=17'h00001 and tick=1 -> p=00001 (no shift), p4 and p5 still advance.
//    A following long-mode tick -> p=00002.
//  - load seed=0, long mode, tick:
//    - with guard: p=1FFFF after 1 tick.
//    - without guard: p=0 and poly_out=0 after 1000 ticks.
//  - init_L=0 mid-run for 1 cycle:
//    - next cycle p=1FFFF, p4=F, p5=1F, rand_vld=0, rand_q=0.
//    - rd_stb asserted during reset is ignored.

Source files
------------

// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared widths, tap positions and types for the POKEY noise polynomials
package poly_pkg;

   localparam int P4_W        = 4;
   localparam int P5_W        = 5;
   localparam int LONG_W_DEF  = 17;
   localparam int SHORT_W_DEF = 9;

   // Short polys: {tap_a, tap_b} as absolute bit indices
   localparam logic [1:0][7:0] P4_TAPS = {8'd3, 8'd2};
   localparam logic [1:0][7:0] P5_TAPS = {8'd4, 8'd2};

   // Long/short register taps as offsets down from the field width (bit W-offset)
   localparam int LONG_TAP_A  = 1;
   localparam int LONG_TAP_B  = 4;
   localparam int SHORT_TAP_A = 1;
   localparam int SHORT_TAP_B = 5;

   typedef enum logic {MODE_LONG, MODE_SHORT} poly_mode_e;

   typedef logic [LONG_W_DEF-1:0] long_reg_t;

endpackage

// File: rtl/lfsr_fixed.sv
// rtl/lfsr_fixed.sv - fixed-tap Fibonacci shift-left LFSR, resets to all ones, advances on tick
module lfsr_fixed #(
   parameter int W     = 4,
   parameter int TAP_A = 3,
   parameter int TAP_B = 2
) (
   input  logic         clk,
   input  logic         init_L,
   input  logic         tick,
   output logic [W-1:0] state
);

   logic [W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (tick) begin
         state_d = {state_q[W-2:0], state_q[TAP_A] ^ state_q[TAP_B]};
      end
   end

   always_ff @(posedge clk) begin
      if (!init_L) begin
         state_q <= '1;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/poly_noise_bank.sv
// rtl/poly_noise_bank.sv - poly4/poly5/poly17-9 noise bank with seed load and RANDOM capture
// Optional zero-lockup recovery of the long register: POLY_LOCKUP_GUARD_EN
module poly_noise_bank
   import poly_pkg::*;
#(
   parameter int RAND_W  = 8,
   parameter int LONG_W  = LONG_W_DEF,
   parameter int SHORT_W = SHORT_W_DEF
) (
   input  logic              clk,
   input  logic              init_L,
   input  logic              tick,
   input  logic              sel9,
   input  logic              load,
   input  logic [LONG_W-1:0] seed,
   input  logic              rd_stb,
   output logic              poly4_out,
   output logic              poly5_out,
   output logic              poly_out,
   output logic [RAND_W-1:0] rand_q,
   output logic              rand_vld
);

   logic [P4_W-1:0]   p4;
   logic [P5_W-1:0]   p5;
   logic [LONG_W-1:0] p_q, p_d;
   poly_mode_e        mode_q, mode_d;
   logic [RAND_W-1:0] rand_d;
   logic              rand_vld_d;
   logic              long_fb, short_fb;

   lfsr_fixed #(.W(P4_W), .TAP_A(int'(P4_TAPS[1])), .TAP_B(int'(P4_TAPS[0]))) u_p4 (
      .clk(clk), .init_L(init_L), .tick(tick), .state(p4)
   );

   lfsr_fixed #(.W(P5_W), .TAP_A(int'(P5_TAPS[1])), .TAP_B(int'(P5_TAPS[0]))) u_p5 (
      .clk(clk), .init_L(init_L), .tick(tick), .state(p5)
   );

   assign long_fb  = p_q[LONG_W-LONG_TAP_A] ^ p_q[LONG_W-LONG_TAP_B];
   assign short_fb = p_q[SHORT_W-SHORT_TAP_A] ^ p_q[SHORT_W-SHORT_TAP_B];

`ifdef POLY_LOCKUP_GUARD_EN
   logic active_zero;
   assign active_zero = (mode_q == MODE_SHORT) ? (p_q[SHORT_W-1:0] == '0) : (p_q == '0);
`endif

   // Shift uses the registered mode; the newly sampled sel9 only takes effect next tick
   always_comb begin
      p_d        = p_q;
      mode_d     = mode_q;
      rand_d     = rand_q;
      rand_vld_d = rd_stb;
      if (load) begin
         p_d = seed;
      end else if (tick) begin
         if (mode_q == MODE_SHORT) begin
            p_d = {p_q[LONG_W-1:SHORT_W], p_q[SHORT_W-2:0], short_fb};
         end else begin
            p_d = {p_q[LONG_W-2:0], long_fb};
         end
`ifdef POLY_LOCKUP_GUARD_EN
         if (active_zero) begin
            p_d = '1;
         end
`endif
      end
      if (tick) begin
         mode_d = sel9 ? MODE_SHORT : MODE_LONG;
      end
      if (rd_stb) begin
         rand_d = p_q[RAND_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!init_L) begin
         p_q      <= '1;
         mode_q   <= MODE_LONG;
         rand_q   <= '0;
         rand_vld <= 1'b0;
      end else begin
         p_q      <= p_d;
         mode_q   <= mode_d;
         rand_q   <= rand_d;
         rand_vld <= rand_vld_d;
      end
   end

   assign poly4_out = p4[P4_W-1];
   assign poly5_out = p5[P5_W-1];
   assign poly_out  = (mode_q == MODE_SHORT) ? p_q[SHORT_W-1] : p_q[LONG_W-1];

endmodule
